img_rsz: RTL and testbench

- Streaming image down-scaler (box filter).
- Accepts raster-order pixels of a runtime-sized image and sums each pixel into one of RSZ_IMG_HEIGHT_SIZE x RSZ_IMG_WIDTH_SIZE block accumulators.
- Emits one averaged pixel per completed block on a valid/ready output stream.
- Sits between the pixel source (camera or frame reader) and the downstream compute engine; exposes accumulators and per-block completion flags for debug.

---
 rtl/img_rsz.sv | 137 +++++++++++++
 tb/tb_img_rsz.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_rsz.sv
`timescale 1ns/1ps
// img_rsz: streaming box-filter image down-scaler.
//
// Raster-order input pixels are summed into a grid of
// RSZ_IMG_HEIGHT_SIZE x RSZ_IMG_WIDTH_SIZE block accumulators. When the
// bottom-right pixel of a block arrives, the block is flagged complete.
// A raster-order drain pointer emits one averaged pixel per completed
// block on a valid/ready stream and then clears that block.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   ImgWidth, ImgHeight        input image size in pixels (stable per frame)
//   PxlData/PxlX/PxlY          input pixel components and coordinates
//   PxlVld/PxlRdy              input handshake
//   RszPxlData/RszPxlX/RszPxlY averaged pixel and its block coordinates
//   RszPxlVld/RszPxlRdy        output handshake
//   FcRszPxlBuf                all block accumulators (debug view)
//   RszPxlParVld               per-block "complete, not yet drained" flags
module img_rsz #(
    parameter int PXL_PRIM_COLOR_W     = 8,
    parameter int PXL_PRIM_COLOR_NUM   = 3,
    parameter int IMG_WIDTH_IDX_W      = 10,
    parameter int IMG_HEIGHT_IDX_W     = 10,
    parameter int RSZ_IMG_WIDTH_SIZE   = 16,
    parameter int RSZ_IMG_HEIGHT_SIZE  = 8,
    parameter int RSZ_IMG_WIDTH_IDX_W  = 4,
    parameter int RSZ_IMG_HEIGHT_IDX_W = 3,
    parameter int ACC_W                = 20
) (
    input  logic                                                  Clk,
    input  logic                                                  Reset,
    input  logic [IMG_WIDTH_IDX_W-1:0]                            ImgWidth,
    input  logic [IMG_HEIGHT_IDX_W-1:0]                           ImgHeight,
    input  logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]   PxlData,
    input  logic [IMG_WIDTH_IDX_W-1:0]                            PxlX,
    input  logic [IMG_HEIGHT_IDX_W-1:0]                           PxlY,
    input  logic                                                  PxlVld,
    output logic                                                  PxlRdy,
    output logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]   RszPxlData,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]                        RszPxlX,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0]                       RszPxlY,
    output logic                                                  RszPxlVld,
    input  logic                                                  RszPxlRdy,
    output logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0]
                 [PXL_PRIM_COLOR_NUM-1:0][ACC_W-1:0]              FcRszPxlBuf,
    output logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0] RszPxlParVld
);

    localparam int SH_W = 5;

    // Index of the highest set bit; block sizes are powers of two so this is log2.
    function automatic logic [SH_W-1:0] msbIdx(input logic [15:0] v);
        msbIdx = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) msbIdx = SH_W'(i);
        end
    endfunction

    // Block average: divide the sum by the power-of-two pixel count, keep the low bits.
    function automatic logic [PXL_PRIM_COLOR_W-1:0] avgScale(input logic [ACC_W-1:0] acc,
                                                             input logic [SH_W-1:0]  sh);
        avgScale = PXL_PRIM_COLOR_W'(acc >> sh);
    endfunction

    logic [IMG_WIDTH_IDX_W-1:0]      blkW;
    logic [IMG_HEIGHT_IDX_W-1:0]     blkH;
    logic [SH_W-1:0]                 shW;
    logic [SH_W-1:0]                 shH;
    logic [SH_W-1:0]                 shTot;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  bx;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] by;
    logic                            lastX;
    logic                            lastY;
    logic                            accept;
    logic                            blkDone;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  ox;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] oy;
    logic                            load;

    // Input side: block geometry and target block of the current beat
    assign blkW  = ImgWidth  >> RSZ_IMG_WIDTH_IDX_W;
    assign blkH  = ImgHeight >> RSZ_IMG_HEIGHT_IDX_W;
    assign shW   = msbIdx(16'(blkW));
    assign shH   = msbIdx(16'(blkH));
    assign shTot = shW + shH;

    assign bx    = RSZ_IMG_WIDTH_IDX_W'(PxlX >> shW);
    assign by    = RSZ_IMG_HEIGHT_IDX_W'(PxlY >> shH);
    assign lastX = ((PxlX & (blkW - IMG_WIDTH_IDX_W'(1))) == (blkW - IMG_WIDTH_IDX_W'(1)));
    assign lastY = ((PxlY & (blkH - IMG_HEIGHT_IDX_W'(1))) == (blkH - IMG_HEIGHT_IDX_W'(1)));

    // A completed block must be drained before the next frame may add into it.
    assign PxlRdy  = !RszPxlParVld[by][bx];
    assign accept  = PxlVld & PxlRdy;
    assign blkDone = accept & lastX & lastY;

    // Output side: load the block under the drain pointer when the slot is free
    assign load = (!RszPxlVld | RszPxlRdy) & RszPxlParVld[oy][ox];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            FcRszPxlBuf  <= '0;
            RszPxlParVld <= '0;
            RszPxlVld    <= 1'b0;
            RszPxlData   <= '0;
            RszPxlX      <= '0;
            RszPxlY      <= '0;
            ox           <= '0;
            oy           <= '0;
        end else begin
            // Accumulate: never the same block as a load, its flag blocks input
            if (accept) begin
                for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
                    FcRszPxlBuf[by][bx][c] <= FcRszPxlBuf[by][bx][c] + ACC_W'(PxlData[c]);
                end
            end
            if (blkDone) RszPxlParVld[by][bx] <= 1'b1;

            // Drain: register the average and free the block
            if (load) begin
                for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
                    RszPxlData[c] <= avgScale(FcRszPxlBuf[oy][ox][c], shTot);
                end
                RszPxlX              <= ox;
                RszPxlY              <= oy;
                RszPxlVld            <= 1'b1;
                RszPxlParVld[oy][ox] <= 1'b0;
                FcRszPxlBuf[oy][ox]  <= '0;
                // {oy,ox} as one counter gives raster order with wrap to (0,0).
                {oy, ox}             <= {oy, ox} + 1'b1;
            end else if (RszPxlRdy & RszPxlVld) begin
                RszPxlVld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_img_rsz.sv
`timescale 1ns/1ps
module tb_img_rsz;

    localparam int CW  = 8;
    localparam int CN  = 3;
    localparam int XW  = 10;
    localparam int YW  = 10;
    localparam int OW  = 16;
    localparam int OH  = 8;
    localparam int OXW = 4;
    localparam int OYW = 3;
    localparam int AW  = 20;

    logic                          Clk = 1'b0;
    logic                          Reset;
    logic [XW-1:0]                 ImgWidth;
    logic [YW-1:0]                 ImgHeight;
    logic [CN-1:0][CW-1:0]         PxlData;
    logic [XW-1:0]                 PxlX;
    logic [YW-1:0]                 PxlY;
    logic                          PxlVld;
    logic                          PxlRdy;
    logic [CN-1:0][CW-1:0]         RszPxlData;
    logic [OXW-1:0]                RszPxlX;
    logic [OYW-1:0]                RszPxlY;
    logic                          RszPxlVld;
    logic                          RszPxlRdy;
    logic [OH-1:0][OW-1:0][CN-1:0][AW-1:0] FcRszPxlBuf;
    logic [OH-1:0][OW-1:0]         RszPxlParVld;

    always #5 Clk = ~Clk;

    img_rsz dut (
        .Clk(Clk), .Reset(Reset), .ImgWidth(ImgWidth), .ImgHeight(ImgHeight),
        .PxlData(PxlData), .PxlX(PxlX), .PxlY(PxlY), .PxlVld(PxlVld), .PxlRdy(PxlRdy),
        .RszPxlData(RszPxlData), .RszPxlX(RszPxlX), .RszPxlY(RszPxlY),
        .RszPxlVld(RszPxlVld), .RszPxlRdy(RszPxlRdy),
        .FcRszPxlBuf(FcRszPxlBuf), .RszPxlParVld(RszPxlParVld)
    );

    int passCnt = 0;
    int totCnt  = 0;

    // Source frame, row stride 128, each entry {c2,c1,c0}.
    bit   [23:0] frm [0:8191];
    logic [30:0] expQ[$];
    logic [30:0] gotQ[$];

    // ---------------- reference model ----------------
    function automatic void fill_ramp(int w, int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                frm[y*128 + x] = {16'h0, 8'(x)};
    endfunction

    function automatic void fill_rand(int w, int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                frm[y*128 + x] = 24'($urandom);
    endfunction

    // Average of every block, appended in raster order of blocks.
    function automatic void build_expected(int w, int h);
        int bw = w / OW;
        int bh = h / OH;
        for (int by = 0; by < OH; by++) begin
            for (int bx = 0; bx < OW; bx++) begin
                bit [23:0] d = '0;
                for (int c = 0; c < CN; c++) begin
                    int sum = 0;
                    for (int yy = 0; yy < bh; yy++) begin
                        for (int xx = 0; xx < bw; xx++) begin
                            bit [23:0] p = frm[(by*bh + yy)*128 + bx*bw + xx];
                            sum += int'(p[c*8 +: 8]);
                        end
                    end
                    d[c*8 +: 8] = 8'(sum / (bw*bh));
                end
                expQ.push_back({4'(bx), 3'(by), d});
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        Reset     = 1'b1;
        PxlVld    = 1'b0;
        PxlX      = '0;
        PxlY      = '0;
        PxlData   = '0;
        RszPxlRdy = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    // Present one pixel and hold it until an edge accepts it; returns 1ns after that edge.
    task automatic feed_pixel(int x, int y, bit [23:0] d);
        logic rdy;
        PxlX    = XW'(x);
        PxlY    = YW'(y);
        PxlData = d;
        PxlVld  = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            #1;
            rdy = PxlRdy;
            @(posedge Clk);
            #1;
            if (rdy) return;
        end
        totCnt++;
        $display("FAIL feed_timeout pixel (%0d,%0d): not accepted, required accepted within 4000 cycles", x, y);
    endtask

    task automatic feed_frame(int w, int h, int start, int stop, bit inBub);
        for (int i = start; i < stop; i++) begin
            if (inBub) begin
                int n = $urandom_range(0, 2);
                if (n != 0) begin
                    PxlVld = 1'b0;
                    repeat (n) @(posedge Clk);
                    #1;
                end
            end
            feed_pixel(i % w, i / w, frm[(i / w)*128 + (i % w)]);
        end
        PxlVld = 1'b0;
    endtask

    task automatic collect(int n, bit outBub);
        int cyc = 0;
        while (gotQ.size() < n && cyc < 40000) begin
            RszPxlRdy = outBub ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (RszPxlVld && RszPxlRdy) gotQ.push_back({RszPxlX, RszPxlY, RszPxlData});
            @(posedge Clk);
            #1;
            cyc++;
        end
        RszPxlRdy = 1'b1;
    endtask

    task automatic compare_outputs(string name);
        totCnt++;
        if (gotQ.size() !== expQ.size())
            $display("FAIL %s_count: got %0d outputs, required %0d", name, gotQ.size(), expQ.size());
        else passCnt++;
        for (int i = 0; i < expQ.size(); i++) begin
            totCnt++;
            if (i >= gotQ.size())
                $display("FAIL %s[%0d]: missing, required %h", name, i, expQ[i]);
            else if (gotQ[i] !== expQ[i])
                $display("FAIL %s[%0d]: got {X,Y,D}=%h, required %h", name, i, gotQ[i], expQ[i]);
            else passCnt++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ImgWidth  = 10'd128;
        ImgHeight = 10'd64;
        do_reset();
        totCnt++; if (RszPxlVld !== 1'b0) $display("FAIL reset_vld: got %b, required 0", RszPxlVld); else passCnt++;
        totCnt++; if (RszPxlParVld !== '0) $display("FAIL reset_parvld: got %h, required 0", RszPxlParVld); else passCnt++;
        totCnt++; if (FcRszPxlBuf !== '0) $display("FAIL reset_accbuf: got nonzero, required 0"); else passCnt++;
        totCnt++; if (PxlRdy !== 1'b1) $display("FAIL reset_pxlrdy: got %b, required 1", PxlRdy); else passCnt++;
    endtask

    task automatic test_ramp();
        do_reset();
        fill_ramp(128, 64);
        expQ.delete(); gotQ.delete();
        build_expected(128, 64);
        fork
            feed_frame(128, 64, 0, 128*64, 1'b0);
            collect(128, 1'b0);
        join
        compare_outputs("ramp");
        totCnt++;
        if (gotQ.size() != 128 || gotQ[127][7:0] !== 8'd123)
            $display("FAIL ramp_last: got %h, required X=15 Y=7 Data0=123", gotQ.size() > 0 ? gotQ[gotQ.size()-1] : 31'h0);
        else passCnt++;
    endtask

    task automatic test_bubbles();
        do_reset();
        fill_ramp(128, 64);
        expQ.delete(); gotQ.delete();
        build_expected(128, 64);
        fork
            feed_frame(128, 64, 0, 128*64, 1'b1);
            collect(128, 1'b1);
        join
        compare_outputs("bubble_ramp");
        do_reset();
        fill_rand(128, 64);
        expQ.delete(); gotQ.delete();
        build_expected(128, 64);
        fork
            feed_frame(128, 64, 0, 128*64, 1'b1);
            collect(128, 1'b1);
        join
        compare_outputs("bubble_rand");
    endtask

    task automatic test_latency();
        do_reset();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                feed_pixel(x, y, {16'h0, 8'(x)});
        PxlVld = 1'b0;
        // now 1ns after edge N, which accepted pixel (7,7)
        totCnt++; if (RszPxlParVld[0][0] !== 1'b1) $display("FAIL lat_parvld: got %b, required 1", RszPxlParVld[0][0]); else passCnt++;
        totCnt++; if (RszPxlVld !== 1'b0) $display("FAIL lat_vld_early: got %b, required 0", RszPxlVld); else passCnt++;
        @(posedge Clk);
        #1;
        totCnt++;
        if (RszPxlVld !== 1'b1 || RszPxlX !== 4'd0 || RszPxlY !== 3'd0 || RszPxlData[0] !== 8'd3)
            $display("FAIL lat_out: got vld=%b X=%0d Y=%0d D0=%0d, required vld=1 X=0 Y=0 D0=3",
                     RszPxlVld, RszPxlX, RszPxlY, RszPxlData[0]);
        else passCnt++;
    endtask

    task automatic test_stall();
        logic [OH-1:0][OW-1:0] pv;
        do_reset();
        fill_ramp(128, 64);
        RszPxlRdy = 1'b0;
        feed_frame(128, 64, 0, 128*64, 1'b0);
        repeat (3) @(posedge Clk);
        #1;
        totCnt++;
        if (RszPxlVld !== 1'b1 || RszPxlX !== 4'd0 || RszPxlY !== 3'd0 || RszPxlData[0] !== 8'd3)
            $display("FAIL stall_hold: got vld=%b X=%0d Y=%0d D0=%0d, required vld=1 X=0 Y=0 D0=3",
                     RszPxlVld, RszPxlX, RszPxlY, RszPxlData[0]);
        else passCnt++;
        pv = '1;
        pv[0][0] = 1'b0;
        totCnt++; if (RszPxlParVld !== pv) $display("FAIL stall_parvld: got %h, required %h", RszPxlParVld, pv); else passCnt++;
        for (int x = 0; x < 8; x++) feed_pixel(x, 0, frm[x]);
        PxlX = 10'd8; PxlY = 10'd0; PxlData = frm[8]; PxlVld = 1'b1;
        #1;
        totCnt++; if (PxlRdy !== 1'b0) $display("FAIL stall_pxlrdy: got %b, required 0", PxlRdy); else passCnt++;
        repeat (3) @(posedge Clk);
        #1;
        totCnt++; if (PxlRdy !== 1'b0) $display("FAIL stall_pxlrdy_hold: got %b, required 0", PxlRdy); else passCnt++;
        expQ.delete(); gotQ.delete();
        build_expected(128, 64);
        build_expected(128, 64);
        fork
            feed_frame(128, 64, 8, 128*64, 1'b0);
            collect(256, 1'b0);
        join
        compare_outputs("stall_drain");
    endtask

    task automatic test_small_reset();
        ImgWidth  = 10'd64;
        ImgHeight = 10'd32;
        do_reset();
        fill_ramp(64, 32);
        expQ.delete(); gotQ.delete();
        build_expected(64, 32);
        fork
            feed_frame(64, 32, 0, 64*32, 1'b0);
            collect(128, 1'b1);
        join
        compare_outputs("small");
        totCnt++;
        if (gotQ.size() < 6 || gotQ[5][7:0] !== 8'd21)
            $display("FAIL small_x5: got %h, required Data0=21", gotQ.size() > 5 ? gotQ[5] : 31'h0);
        else passCnt++;
        // partial frame, then reset mid-frame
        feed_frame(64, 32, 0, 1000, 1'b1);
        do_reset();
        totCnt++; if (RszPxlParVld !== '0) $display("FAIL mid_parvld: got %h, required 0", RszPxlParVld); else passCnt++;
        totCnt++; if (FcRszPxlBuf !== '0) $display("FAIL mid_accbuf: got nonzero, required 0"); else passCnt++;
        totCnt++; if (RszPxlVld !== 1'b0) $display("FAIL mid_vld: got %b, required 0", RszPxlVld); else passCnt++;
        gotQ.delete();
        fork
            feed_frame(64, 32, 0, 64*32, 1'b0);
            collect(128, 1'b0);
        join
        totCnt++;
        if (gotQ.size() == 0 || gotQ[0] !== {4'd0, 3'd0, 24'd1})
            $display("FAIL mid_first: got %h, required %h", gotQ.size() > 0 ? gotQ[0] : 31'h0, {4'd0, 3'd0, 24'd1});
        else passCnt++;
        compare_outputs("mid_restart");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_bubbles();
        test_latency();
        test_stall();
        test_small_reset();
        $display("%0d/%0d checks passed", passCnt, totCnt);
        $finish;
    end

endmodule
